// File: rtl/chipset_cycle_decoder_pkg.sv
// Shared definitions for the chipset cycle decoder: access states, address
// match constants and 68040 SIZ/TT encodings.
package chipset_cycle_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAM  = 2'd1,
      REG  = 2'd2
   } state_t;

   // Chip RAM occupies 0x000000-0x1FFFFF: everything above bit 20 must be zero.
   localparam logic [10:0] CHIPRAM_HI_ZERO = 11'h000;
   // Custom registers occupy the 4 KiB page at 0xDFF000.
   localparam logic [19:0] REGSPACE_PAGE   = 20'h00DFF;

   // 68040 SIZ1:SIZ0 encodings.
   localparam logic [1:0] SIZ_LONG = 2'b00;
   localparam logic [1:0] SIZ_BYTE = 2'b01;
   localparam logic [1:0] SIZ_WORD = 2'b10;
   localparam logic [1:0] SIZ_LINE = 2'b11;

   // 68040 TT1:TT0 encodings this block responds to.
   localparam logic [1:0] TT_NORMAL = 2'b00;
   localparam logic [1:0] TT_MOVE16 = 2'b01;

endpackage

// File: rtl/chipset_cycle_decoder_watchdog.sv
// cycle_watchdog: counts CLK40 edges an access spends without nTA and raises
// a one-cycle nTEA pulse when TIMEOUT_CYCLES is reached. Instantiated by the
// top only when CYCLE_WATCHDOG_EN is defined.
module cycle_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic CLK40,
   input  logic nRESET,
   input  logic accept,
   input  logic active,
   input  logic nTA,
   output logic timeout,
   output logic nTEA
);

   logic [7:0] count;

   // nTA on the expiring edge wins, so the timeout only fires without nTA.
   assign timeout = active && nTA && (count == 8'(TIMEOUT_CYCLES - 1));

   // Timeout counter: clears on accept, counts edges waiting for nTA.
   always_ff @(posedge CLK40 or negedge nRESET) begin
      if (!nRESET) begin
         count <= 8'd0;
      end else if (accept || timeout) begin
         count <= 8'd0;
      end else if (active && nTA) begin
         count <= count + 8'd1;
      end
   end

   // nTEA is a registered single-cycle pulse following the expiring edge.
   always_ff @(posedge CLK40 or negedge nRESET) begin
      if (!nRESET) begin
         nTEA <= 1'b1;
      end else begin
         nTEA <= !timeout;
      end
   end

endmodule

// File: rtl/chipset_cycle_decoder.sv
// chipset_cycle_decoder: samples 68040 nTS, decodes chip RAM / custom register
// space and holds the selected space strobe until the cycle's final nTA,
// tracking line-burst beats and nTBI. Optional watchdog: CYCLE_WATCHDOG_EN.
module chipset_cycle_decoder
   import chipset_cycle_decoder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        CLK40,
   input  logic        nRESET,
   input  logic        nTS,
   input  logic        TT0,
   input  logic        TT1,
   input  logic        SIZ0,
   input  logic        SIZ1,
   input  logic [31:0] A,
   input  logic        nTA,
   input  logic        nTBI,
   output logic        nRAMSPACE,
   output logic        nREGSPACE,
   output logic        LINE_CYCLE,
   output logic [1:0]  BEAT,
   output logic        nTEA
);

   state_t     state, state_nxt;
   logic [1:0] beat_nxt;
   logic       line_nxt;
   logic       accept;
   logic       timeout;
   logic       ram_hit, reg_hit, is_line;

   // The page offset never takes part in the decode.
   logic unused_addr_bits;
   assign unused_addr_bits = ^A[11:0];

   assign ram_hit = (A[31:21] == CHIPRAM_HI_ZERO);
   assign reg_hit = (A[31:12] == REGSPACE_PAGE);
   assign is_line = ({SIZ1, SIZ0} == SIZ_LINE) || ({TT1, TT0} == TT_MOVE16);

   // Space strobes come straight from the state register, so reset releases
   // them immediately.
   assign nRAMSPACE = (state != RAM);
   assign nREGSPACE = (state != REG);

   // Next-state and beat tracking.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path can
      // leave it unassigned and infer a latch.
      state_nxt = state;
      beat_nxt  = BEAT;
      line_nxt  = LINE_CYCLE;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!nTS && !TT1) begin
               if (ram_hit) begin
                  accept    = 1'b1;
                  state_nxt = RAM;
                  line_nxt  = is_line;
                  beat_nxt  = 2'd0;
               end else if (reg_hit) begin
                  // U712 splits register line accesses itself: always 1 beat.
                  accept    = 1'b1;
                  state_nxt = REG;
                  line_nxt  = 1'b0;
                  beat_nxt  = 2'd0;
               end
            end
         end
         RAM, REG: begin
            if (!nTA) begin
               if (LINE_CYCLE && (BEAT != 2'd3) && nTBI) begin
                  beat_nxt = BEAT + 2'd1;
               end else begin
                  state_nxt = IDLE;
                  beat_nxt  = 2'd0;
                  line_nxt  = 1'b0;
               end
            end else if (timeout) begin
               state_nxt = IDLE;
               beat_nxt  = 2'd0;
               line_nxt  = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
            beat_nxt  = 2'd0;
            line_nxt  = 1'b0;
         end
      endcase
   end

   // State, beat and line registers.
   always_ff @(posedge CLK40 or negedge nRESET) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!nRESET) begin
         state      <= IDLE;
         BEAT       <= 2'd0;
         LINE_CYCLE <= 1'b0;
      end else begin
         state      <= state_nxt;
         BEAT       <= beat_nxt;
         LINE_CYCLE <= line_nxt;
      end
   end

`ifdef CYCLE_WATCHDOG_EN
   cycle_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_cycle_watchdog (
      .CLK40   (CLK40),
      .nRESET  (nRESET),
      .accept  (accept),
      .active  (state != IDLE),
      .nTA     (nTA),
      .timeout (timeout),
      .nTEA    (nTEA)
   );
`else
   // Without the watchdog accesses wait indefinitely for nTA.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES) ^ accept;
   assign timeout = 1'b0;
   assign nTEA    = 1'b1;
`endif

endmodule

// File: tb/tb_chipset_cycle_decoder.sv
// Scoreboard bench for chipset_cycle_decoder: the stimulus process pushes the
// hand-computed expected outputs after each edge, a monitor pops and compares.
// Watchdog scenarios are selected with CYCLE_WATCHDOG_EN.
`timescale 1ns/1ps
module tb_chipset_cycle_decoder;

   logic        clk40 = 1'b0;
   logic        n_reset;
   logic        n_ts, tt0, tt1, siz0, siz1, n_ta, n_tbi;
   logic [31:0] addr;
   logic        n_ramspace, n_regspace, line_cycle, n_tea;
   logic [1:0]  beat;

   int checks = 0;
   int errors = 0;

   // Expected output word: {nRAMSPACE, nREGSPACE, LINE_CYCLE, BEAT[1:0], nTEA}
   localparam logic [5:0] O_IDLE = 6'b11_0_00_1;
   localparam logic [5:0] O_RAM  = 6'b01_0_00_1;
   localparam logic [5:0] O_REG  = 6'b10_0_00_1;
   localparam logic [5:0] O_L0   = 6'b01_1_00_1;
   localparam logic [5:0] O_L1   = 6'b01_1_01_1;
   localparam logic [5:0] O_L2   = 6'b01_1_10_1;
   localparam logic [5:0] O_L3   = 6'b01_1_11_1;
   localparam logic [5:0] O_TEA  = 6'b11_0_00_0;

   logic [5:0] exp_q[$];
   int         step_no = 0;

   chipset_cycle_decoder #(.TIMEOUT_CYCLES(8)) dut (
      .CLK40      (clk40),
      .nRESET     (n_reset),
      .nTS        (n_ts),
      .TT0        (tt0),
      .TT1        (tt1),
      .SIZ0       (siz0),
      .SIZ1       (siz1),
      .A          (addr),
      .nTA        (n_ta),
      .nTBI       (n_tbi),
      .nRAMSPACE  (n_ramspace),
      .nREGSPACE  (n_regspace),
      .LINE_CYCLE (line_cycle),
      .BEAT       (beat),
      .nTEA       (n_tea)
   );

   always #12.5 clk40 = ~clk40;

   function automatic logic [5:0] outs();
      return {n_ramspace, n_regspace, line_cycle, beat, n_tea};
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {nRAM,nREG,LINE,BEAT,nTEA}=%b required %b", name, act, exp);
      end
   endtask

   // Monitor: outputs are sampled on the falling edge, half a cycle after the
   // rising edge that produced them.
   initial begin
      forever begin
         @(negedge clk40);
         if (exp_q.size() > 0) begin
            logic [5:0] e;
            e = exp_q.pop_front();
            step_no++;
            check($sformatf("step%0d", step_no), outs(), e);
         end
      end
   end

   // Apply one cycle of inputs and queue the outputs expected after the edge.
   task automatic step(input logic nts, input logic [1:0] tt, input logic [1:0] siz,
                       input logic [31:0] a, input logic nta, input logic ntbi,
                       input logic [5:0] exp);
      @(negedge clk40);
      n_ts = nts; {tt1, tt0} = tt; {siz1, siz0} = siz; addr = a;
      n_ta = nta; n_tbi = ntbi;
      @(posedge clk40);
      #1;
      exp_q.push_back(exp);
   endtask

   // Cycle with nTS deasserted.
   task automatic wait_ta(input logic nta, input logic ntbi, input logic [5:0] exp);
      step(1'b1, 2'b00, 2'b00, 32'h0, nta, ntbi, exp);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         @(negedge clk40);
         n++;
      end
      #1;
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
   endtask

   initial begin
      n_reset = 1'b0;
      n_ts = 1'b1; {tt1, tt0} = 2'b00; {siz1, siz0} = 2'b00; addr = 32'h0;
      n_ta = 1'b1; n_tbi = 1'b1;
      #3;
      check("reset_state", outs(), O_IDLE);
      @(negedge clk40);
      n_reset = 1'b1;

      // Long read to chip RAM, nTA on the fifth cycle.
      step(1'b0, 2'b00, 2'b00, 32'h0000_1000, 1'b1, 1'b1, O_RAM);
      wait_ta(1'b1, 1'b1, O_RAM);
      wait_ta(1'b1, 1'b1, O_RAM);
      wait_ta(1'b1, 1'b1, O_RAM);
      wait_ta(1'b0, 1'b1, O_IDLE);
      wait_ta(1'b1, 1'b1, O_IDLE);

      // Line read, four beats with one wait state after beat 0.
      step(1'b0, 2'b00, 2'b11, 32'h0010_0000, 1'b1, 1'b1, O_L0);
      wait_ta(1'b0, 1'b1, O_L1);
      wait_ta(1'b1, 1'b1, O_L1);
      wait_ta(1'b0, 1'b1, O_L2);
      wait_ta(1'b0, 1'b1, O_L3);
      wait_ta(1'b0, 1'b1, O_IDLE);

      // Line read terminated by burst inhibit on the first nTA.
      step(1'b0, 2'b00, 2'b11, 32'h0010_0000, 1'b1, 1'b1, O_L0);
      wait_ta(1'b0, 1'b0, O_IDLE);

      // MOVE16 is a line transfer regardless of SIZ; nTBI after beat 1.
      step(1'b0, 2'b01, 2'b00, 32'h001F_FFF0, 1'b1, 1'b1, O_L0);
      wait_ta(1'b0, 1'b1, O_L1);
      wait_ta(1'b0, 1'b0, O_IDLE);

      // Word write to custom registers.
      step(1'b0, 2'b00, 2'b10, 32'h00DF_F180, 1'b1, 1'b1, O_REG);
      wait_ta(1'b0, 1'b1, O_IDLE);
      // Register line access is a single beat with LINE_CYCLE low.
      step(1'b0, 2'b00, 2'b11, 32'h00DF_F000, 1'b1, 1'b1, O_REG);
      wait_ta(1'b0, 1'b1, O_IDLE);

      // Unclaimed address, first address past chip RAM, and TT1=1.
      step(1'b0, 2'b00, 2'b00, 32'h00E0_0000, 1'b1, 1'b1, O_IDLE);
      step(1'b0, 2'b00, 2'b00, 32'h0020_0000, 1'b1, 1'b1, O_IDLE);
      step(1'b0, 2'b10, 2'b00, 32'h0000_1000, 1'b1, 1'b1, O_IDLE);

      // nTS during an active access is ignored.
      step(1'b0, 2'b00, 2'b00, 32'h0000_2000, 1'b1, 1'b1, O_RAM);
      step(1'b0, 2'b00, 2'b10, 32'h00DF_F180, 1'b1, 1'b1, O_RAM);
      wait_ta(1'b0, 1'b1, O_IDLE);

      // Back-to-back: nTS with the final nTA is ignored, next edge accepts.
      step(1'b0, 2'b00, 2'b00, 32'h0000_3000, 1'b1, 1'b1, O_RAM);
      step(1'b0, 2'b00, 2'b00, 32'h0000_4000, 1'b0, 1'b1, O_IDLE);
      step(1'b0, 2'b00, 2'b00, 32'h0000_4000, 1'b1, 1'b1, O_RAM);
      wait_ta(1'b0, 1'b1, O_IDLE);

`ifdef CYCLE_WATCHDOG_EN
      // No nTA: the eighth waiting edge fires nTEA for one cycle.
      step(1'b0, 2'b00, 2'b00, 32'h0000_5000, 1'b1, 1'b1, O_RAM);
      for (int i = 0; i < 7; i++) wait_ta(1'b1, 1'b1, O_RAM);
      wait_ta(1'b1, 1'b1, O_TEA);
      wait_ta(1'b1, 1'b1, O_IDLE);
      // nTA on the expiring edge wins and nTEA stays high.
      step(1'b0, 2'b00, 2'b00, 32'h0000_5000, 1'b1, 1'b1, O_RAM);
      for (int i = 0; i < 7; i++) wait_ta(1'b1, 1'b1, O_RAM);
      wait_ta(1'b0, 1'b1, O_IDLE);
      wait_ta(1'b1, 1'b1, O_IDLE);
`else
      // Without the watchdog a hung access simply keeps waiting.
      step(1'b0, 2'b00, 2'b00, 32'h0000_5000, 1'b1, 1'b1, O_RAM);
      for (int i = 0; i < 12; i++) wait_ta(1'b1, 1'b1, O_RAM);
      wait_ta(1'b0, 1'b1, O_IDLE);
`endif

      // Asynchronous reset in the middle of a line transfer.
      step(1'b0, 2'b00, 2'b11, 32'h0000_0040, 1'b1, 1'b1, O_L0);
      wait_ta(1'b0, 1'b1, O_L1);
      drain();
      #2;
      n_reset = 1'b0;
      #1;
      check("async_reset_mid_line", outs(), O_IDLE);
      @(negedge clk40);
      n_reset = 1'b1;
      wait_ta(1'b0, 1'b1, O_IDLE);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit so the bench always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, required completion");
      $fatal(1, "time limit");
   end

endmodule
